// File: rtl/buzzer_pattern_gen.sv
// buzzer_pattern_gen: plays N beeps of square-wave (or DC) tone separated by silent gaps,
// with ms timing derived from a clock prescaler and a ready/busy/done handshake.
module buzzer_pattern_gen #(
    parameter int   CLK_HZ       = 1_000_000,
    parameter int   SIM_TICK_DIV = 0,
    parameter int   MS_W         = 12,
    parameter int   CNT_W        = 8,
    parameter int   HP_W         = 12,
    parameter logic PIN_ACT_LVL  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [MS_W-1:0]  on_ms_i,
    input  logic [MS_W-1:0]  off_ms_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [HP_W-1:0]  half_per_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [CNT_W-1:0] beeps_left_o,
    output logic             pin_o
);
    localparam int TICK_DIV = SIM_TICK_DIV > 0 ? SIM_TICK_DIV : CLK_HZ / 1000;
    localparam int PW       = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

    state_t            state;
    logic [PW-1:0]     presc;
    logic [MS_W-1:0]   ms, on_ms, off_ms;
    logic [HP_W-1:0]   hp, hc;
    logic              tick, accept, last_ms;

    assign tick    = presc == PW'(TICK_DIV - 1);
    assign accept  = state == IDLE && start_i && !abort_i;
    assign last_ms = tick && ms == MS_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            presc        <= '0;
            ms           <= '0;
            on_ms        <= '0;
            off_ms       <= '0;
            hp           <= '0;
            hc           <= '0;
            ready_o      <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            aborted_o    <= 1'b0;
            beeps_left_o <= '0;
            pin_o        <= ~PIN_ACT_LVL;
        end else begin
            // restarting the prescaler on accept keeps every ms exactly TICK_DIV cycles
            presc  <= (accept || tick) ? '0 : presc + 1'b1;
            done_o <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    on_ms        <= on_ms_i;
                    off_ms       <= off_ms_i;
                    hp           <= half_per_i;
                    beeps_left_o <= count_i;
                    aborted_o    <= 1'b0;
                    ready_o      <= 1'b0;
                    busy_o       <= 1'b1;
                    if (count_i == '0 || on_ms_i == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        state <= ON;
                        ms    <= on_ms_i;
                        hc    <= '0;
                        pin_o <= PIN_ACT_LVL;
                    end
                end
                ON, OFF: if (abort_i) begin
                    state        <= DONE;
                    done_o       <= 1'b1;
                    aborted_o    <= 1'b1;
                    beeps_left_o <= '0;
                    pin_o        <= ~PIN_ACT_LVL;
                end else if (state == ON && last_ms) begin
                    beeps_left_o <= beeps_left_o - 1'b1;
                    hc           <= '0;
                    if (beeps_left_o == CNT_W'(1)) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        pin_o  <= ~PIN_ACT_LVL;
                    end else if (off_ms == '0) begin
                        ms    <= on_ms;
                        pin_o <= PIN_ACT_LVL;
                    end else begin
                        state <= OFF;
                        ms    <= off_ms;
                        pin_o <= ~PIN_ACT_LVL;
                    end
                end else if (state == OFF && last_ms) begin
                    state <= ON;
                    ms    <= on_ms;
                    hc    <= '0;
                    pin_o <= PIN_ACT_LVL;
                end else begin
                    if (tick) ms <= ms - 1'b1;
                    if (state == ON && hp != '0) begin
                        hc    <= (hc == hp - 1'b1) ? '0 : hc + 1'b1;
                        pin_o <= (hc == hp - 1'b1) ? ~pin_o : pin_o;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_buzzer_pattern_gen.sv
// tb_buzzer_pattern_gen: directed and random patterns checked cycle by cycle against
// an expected-waveform queue built from the beep/gap/tone rules.
module tb_buzzer_pattern_gen;
    localparam int TD = 4;

    typedef struct packed {
        logic       pin;
        logic       ready;
        logic       busy;
        logic       done;
        logic [7:0] bl;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, abort = 1'b0;
    logic [11:0] on_ms = '0, off_ms = '0, half_per = '0;
    logic [7:0]  count = '0;
    logic        ready, busy, done, aborted, pin;
    logic [7:0]  beeps_left;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    buzzer_pattern_gen #(.SIM_TICK_DIV(TD), .PIN_ACT_LVL(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
        .on_ms_i(on_ms), .off_ms_i(off_ms), .count_i(count), .half_per_i(half_per),
        .ready_o(ready), .busy_o(busy), .done_o(done), .aborted_o(aborted),
        .beeps_left_o(beeps_left), .pin_o(pin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_idle(input logic [7:0] bl, input logic ab);
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check("idle_pin", 32'(pin), 32'd0);
        check("idle_beeps", 32'(beeps_left), 32'(bl));
        check("idle_aborted", 32'(aborted), 32'(ab));
    endtask

    // ab: index of the expected-cycle during which abort_i is held (-1 = none)
    task automatic run(input int on, input int off, input int cnt, input int hp, input int ab_req);
        exp_t q[$];
        int   ab = ab_req;
        bit   zero = (cnt == 0 || on == 0);
        if (zero) q.push_back('{pin: 1'b0, ready: 1'b0, busy: 1'b1, done: 1'b1, bl: 8'(cnt)});
        else begin
            for (int b = 0; b < cnt; b++) begin
                for (int t = 0; t < on * TD; t++)
                    q.push_back('{pin: (hp == 0) ? 1'b1 : ((t / hp) % 2 == 0), ready: 1'b0,
                                  busy: 1'b1, done: 1'b0, bl: 8'(cnt - b)});
                if (b < cnt - 1)
                    for (int t = 0; t < off * TD; t++)
                        q.push_back('{pin: 1'b0, ready: 1'b0, busy: 1'b1, done: 1'b0, bl: 8'(cnt - b - 1)});
            end
            q.push_back('{pin: 1'b0, ready: 1'b0, busy: 1'b1, done: 1'b1, bl: 8'd0});
        end
        if (ab >= q.size() - 1) ab = -1;
        if (ab >= 0) begin
            while (q.size() > ab + 1) void'(q.pop_back());
            q.push_back('{pin: 1'b0, ready: 1'b0, busy: 1'b1, done: 1'b1, bl: 8'd0});
        end
        on_ms = 12'(on); off_ms = 12'(off); count = 8'(cnt); half_per = 12'(hp);
        start = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        on_ms = 12'($urandom); off_ms = 12'($urandom); count = 8'($urandom); half_per = 12'($urandom);
        for (int i = 0; i < q.size(); i++) begin
            bit last = (i == q.size() - 1);
            check("pin", 32'(pin), 32'(q[i].pin));
            check("ready", 32'(ready), 32'(q[i].ready));
            check("busy", 32'(busy), 32'(q[i].busy));
            check("done", 32'(done), 32'(q[i].done));
            check("beeps_left", 32'(beeps_left), 32'(q[i].bl));
            check("aborted", 32'(aborted), 32'(ab >= 0 && last));
            start = !last && ($urandom % 4 == 0);
            abort = last ? 1'($urandom % 2) : (i == ab);
            @(negedge clk);
        end
        start = 1'b0;
        check_idle((ab < 0 && zero) ? 8'(cnt) : 8'd0, ab >= 0);
        abort = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle(8'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle(8'd0, 1'b0);

        run(2, 1, 2, 1, -1);
        run(1, 0, 1, 0, -1);
        run(1, 0, 3, 2, -1);
        run(2, 1, 5, 1, 2);
        run(1, 1, 2, 3, -1);
        run(1, 1, 0, 1, -1);
        run(0, 1, 3, 1, -1);

        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        check("start_abort_ready", 32'(ready), 32'd1);
        @(negedge clk);
        check("start_abort_done", 32'(done), 32'd0);

        for (int n = 0; n < 40; n++)
            run($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 4), $urandom_range(0, 3),
                ($urandom % 3 == 0) ? int'($urandom_range(0, 60)) : -1);

        on_ms = 12'd2; off_ms = 12'd1; count = 8'd3; half_per = 12'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_pin", 32'(pin), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_beeps", 32'(beeps_left), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        run(1, 1, 2, 2, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
